pes_seq_div: RTL and testbench

Sequential restoring divider, the inverse companion of the team's 4x4 sequential multiplier (pes_se_M). It takes a DW-bit dividend and a VW-bit divisor and produces a DW-bit quotient and a VW-bit remainder, one quotient bit per clock. Operands arrive on a valid/ready input handshake and results leave on a valid/ready output handshake. The block sits beside pes_se_M inside user_proj_example, so that products can be checked by dividing back.

---
 rtl/pes_div_pkg.sv | 18 +
 rtl/pes_seq_div_step.sv | 24 ++
 rtl/pes_seq_div.sv | 113 +++++++++++
 tb/tb_pes_seq_div.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pes_div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding,
// default operand widths and the step-counter width helper.
package pes_div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    function automatic int cw_of(input int dw);
        return $clog2(dw + 1);
    endfunction

    localparam int CW = cw_of(DW_DEF);

endpackage

// File: rtl/pes_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module pes_div_step
    import pes_div_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] rem_o,
    output logic          qbit_o
);

    logic [VW:0] t;

    always_comb begin
        t      = {rem_i, bit_i};
        qbit_o = (t >= {1'b0, divisor_i});
        // The true result is below the divisor, so modulo-2^VW subtraction is exact.
        rem_o  = t[VW-1:0] - (qbit_o ? divisor_i : '0);
    end

endmodule

// File: rtl/pes_seq_div.sv
// Sequential restoring divider, one quotient bit per clock, with valid/ready
// handshakes on both the operand and the result side.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// CALC   | shifting out one quotient bit per cycle
// DONE   | result held on the outputs until out_ready
module pes_seq_div
    import pes_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          busy
);

    localparam int CNT_W = cw_of(DW);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DW);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic [VW-1:0]    rem_q, rem_d;
    logic [VW-1:0]    div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [VW-1:0]    step_rem;
    logic             step_qbit;

    pes_div_step #(.VW(VW)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shift_q[DW-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    if (divisor == '0) begin
                        shift_d = '1;
                        rem_d   = dividend[VW-1:0];
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        shift_d = dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CNT_INIT;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                shift_d = {shift_q[DW-2:0], step_qbit};
                rem_d   = step_rem;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign quotient    = shift_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_pes_seq_div.sv
// Directed and exhaustive checks of pes_seq_div at the default 8/4 widths.
module tb_pes_seq_div;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_ni = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    pes_seq_div #(.DW(8), .VW(4)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Full operation: accept, wait for result, optionally hold off the consumer, then handshake.
    task automatic do_op(input logic [7:0] dd, input logic [3:0] dv,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez,
                         input int hold, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk({tag, "_in_ready"}, in_ready, 1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = ~dd;
        divisor  = ~dv;
        chk({tag, "_acc_in_ready"}, in_ready, 0);
        chk({tag, "_acc_busy"}, busy, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            if (in_ready) chk({tag, "_calc_in_ready"}, in_ready, 0);
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_latency"}, n, (dv == 4'd0) ? 0 : 8);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 8'd5;
            divisor  = 4'd2;
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
            chk({tag, "_hold_quotient"}, quotient, eq);
            chk({tag, "_hold_remainder"}, remainder, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_hs_out_valid"}, out_valid, 0);
        chk({tag, "_hs_in_ready"}, in_ready, 1);
        chk({tag, "_hs_busy"}, busy, 0);
        chk({tag, "_hs_quotient_kept"}, quotient, eq);
    endtask

    initial begin
        logic [7:0] rq;
        logic [3:0] rr;
        int n;

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(posedge wb_clk_i);
        #3 wb_rst_ni = 1'b1;
        tick();

        do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 0, "d200_7");
        do_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 0, "d255_1");
        do_op(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 0, "d255_15");
        do_op(8'd0, 4'd9, 8'd0, 4'd0, 1'b0, 0, "d0_9");
        do_op(8'd37, 4'd0, 8'hFF, 4'd5, 1'b1, 0, "d37_0");
        do_op(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 0, "d100_3");
        do_op(8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 6, "d143_11_bp");

        // Reset after the third CALC cycle must abort without a result.
        dividend = 8'd250;
        divisor  = 4'd6;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("abort_busy_before", busy, 1);
        wb_rst_ni = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_quotient", quotient, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_out_valid_hold", out_valid, 0);
        end
        @(posedge wb_clk_i);
        #3 wb_rst_ni = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("abort_no_result", n, 0);
        do_op(8'd250, 4'd6, 8'd41, 4'd4, 1'b0, 0, "d250_6");

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    rq = 8'hFF;
                    rr = 4'(a);
                end else begin
                    rq = 8'(a / b);
                    rr = 4'(a % b);
                end
                do_op(8'(a), 4'(b), rq, rr, (b == 0), 0, "sweep");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
